wifi_tx_interleaver_ctrl: RTL
=============================

Name: wifi_tx_interleaver_ctrl

Overview:
Sequencer for the WIFI TX block interleaver (48/96/192-bit variants). It gates a serial coded-bit stream from the convolutional encoder/puncturer into the interleaver one OFDM symbol (NCBPS bits) at a time. It waits for the interleaver's per-symbol finished pulse, counts symbols against a programmed frame length, and reports done/error to the TX PHY top controller. It sits between the encoder output and the interleaver input, in the TX chain.

Parameters:
NCBPS, 96, coded bits per OFDM symbol; legal values are 48, 96 and 192 and must match the instantiated interleaver TYPE.
SYM_W, 12, width of the symbol count and programmed frame length.
TIMEOUT, 1023, maximum cycles in WAIT_FIN before the block flags an error.

Ports:
clk  input  1  system clock; all logic is on the rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  one-cycle pulse that begins a frame; honoured only in IDLE
abort  input  1  synchronous abort; returns the block to IDLE from any state
num_symbols  input  SYM_W  frame length in symbols; sampled when start is accepted
src_valid  input  1  encoder bit valid
src_data  input  1  encoder bit
src_ready  output  1  controller accepts a bit this cycle
il_enable  output  1  drives interleaver enable
il_valid_in  output  1  drives interleaver valid_in
il_data_in  output  1  drives interleaver data_in
il_finished  input  1  interleaver finished pulse, one per symbol
busy  output  1  high when state is not IDLE
done  output  1  one-cycle pulse when the frame completes
error  output  1  sticky timeout flag; cleared by the next accepted start or by reset
sym_count  output  SYM_W  symbols completed in the current frame

Behaviour:
- Reset values: state IDLE. src_ready, il_enable, il_valid_in, il_data_in, busy, done and error are all 0. sym_count, bit_cnt and the timeout counter are all 0.
- States: IDLE, LOAD, WAIT_FIN, DONE.
- IDLE:
  - start=1 latches num_symbols into len_q, clears sym_count and error, then moves to LOAD.
  - If start=1 and num_symbols=0, the block goes to DONE instead, and LOAD is never entered.
- LOAD:
  - src_ready = 1 (combinational on state).
  - A transfer happens when src_valid && src_ready. On a transfer, il_valid_in <= 1, il_data_in <= src_data and bit_cnt++.
  - With no transfer, il_valid_in <= 0.
  - Latency from encoder to interleaver is 1 cycle.
  - On the transfer with bit_cnt == NCBPS-1: bit_cnt <= 0, state <= WAIT_FIN, timeout counter cleared.
  - Gaps in src_valid are allowed and do not advance bit_cnt.
- WAIT_FIN:
  - src_ready = 0 and il_valid_in <= 0. The timeout counter increments every cycle.
  - On il_finished=1, sym_count++. If the new sym_count == len_q, go to DONE; otherwise go to LOAD.
  - If the timeout counter reaches TIMEOUT without il_finished, error <= 1 and state <= IDLE. sym_count holds its value.
  - If il_finished arrives in the same cycle the counter reaches TIMEOUT, il_finished wins and no error is raised.
- DONE: done = 1 for exactly one cycle, then IDLE. sym_count holds until the next start.
- il_enable = 1 in LOAD and WAIT_FIN only.
- il_finished is ignored outside WAIT_FIN.
- start is ignored when not in IDLE.
- abort:
  - Synchronous, and has priority over every other event.
  - Next state is IDLE, bit_cnt is cleared, src_ready falls in the same cycle, and il_valid_in and il_enable go to 0 on the next edge.
  - error and sym_count are unchanged, and no done pulse is produced.
- Asynchronous reset mid-frame: everything returns immediately to its reset values and no partial symbol is flushed.
- bit_cnt is sized $clog2(NCBPS). sym_count comparisons are unsigned over SYM_W bits. A len_q of 2^SYM_W-1 is legal.

Test Plan:
- NCBPS=96, start with num_symbols=2, src_valid held high, bench model pulses il_finished 100 cycles after each 96th bit:
  - exactly 192 il_valid_in pulses, each one cycle after its src transfer;
  - sym_count goes 1 then 2;
  - one done pulse;
  - busy falls in the cycle after done.
- src_valid toggling 1/0 every cycle with num_symbols=1: exactly 96 transfers; bit order preserved at il_data_in (bench sends an incrementing LFSR and compares).
- start with num_symbols=0: done pulses 1 cycle after start, il_enable never rises, and no src_ready.
- il_finished withheld, TIMEOUT=1023: error rises exactly 1023 cycles after entry to WAIT_FIN; the block returns to IDLE with sym_count=0. A subsequent start clears error.
- abort asserted at bit 40 of symbol 1 in a 3-symbol frame:
  - src_ready falls the same cycle and the state is IDLE next cycle;
  - no done pulse;
  - a restart sends a full 96 bits per symbol.
- Asynchronous reset asserted mid-LOAD between clock edges: all outputs are 0 before the next rising edge, and a start after release behaves normally.

Source files
------------

// File: rtl/wifi_tx_interleaver_ctrl.sv
// Sequencer that meters a serial coded-bit stream into the WIFI TX block
// interleaver one OFDM symbol (NCBPS bits) at a time.
// Ports:
//   clk, reset            rising-edge clock, async active-high reset
//   start, num_symbols    frame request and its length in symbols (IDLE only)
//   abort                 synchronous return to IDLE, highest priority
//   src_valid/src_data    encoder bit stream in; src_ready is the accept strobe
//   il_enable/il_valid_in/il_data_in  interleaver drive; il_finished per-symbol pulse
//   busy, done, error     status to the TX PHY controller
//   sym_count             symbols completed in the current frame
module wifi_tx_interleaver_ctrl #(
  parameter int unsigned NCBPS   = 96,
  parameter int unsigned SYM_W   = 12,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [SYM_W-1:0] num_symbols,
  input  logic             src_valid,
  input  logic             src_data,
  output logic             src_ready,
  output logic             il_enable,
  output logic             il_valid_in,
  output logic             il_data_in,
  input  logic             il_finished,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [SYM_W-1:0] sym_count
);

  localparam int unsigned BIT_W = (NCBPS > 1) ? $clog2(NCBPS) : 1;
  localparam int unsigned TO_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT_FIN,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [BIT_W-1:0] r_bit_cnt;
  logic [TO_W-1:0]  r_to_cnt;
  logic [SYM_W-1:0] r_len_q;
  logic [SYM_W-1:0] r_sym_count;
  logic             r_il_valid;
  logic             r_il_data;
  logic             r_done;
  logic             r_error;

  logic             w_xfer;
  logic [SYM_W-1:0] w_sym_next;

  // Ready drops in the abort cycle itself so no bit is taken while leaving
  assign src_ready  = (r_state == S_LOAD) && !abort;
  assign w_xfer     = src_valid && src_ready;
  assign w_sym_next = r_sym_count + SYM_W'(1);

  // Pure decodes of the state register
  assign il_enable   = (r_state == S_LOAD) || (r_state == S_WAIT_FIN);
  assign busy        = (r_state != S_IDLE);
  assign il_valid_in = r_il_valid;
  assign il_data_in  = r_il_data;
  assign done        = r_done;
  assign error       = r_error;
  assign sym_count   = r_sym_count;

  // Frame sequencer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_bit_cnt   <= '0;
      r_to_cnt    <= '0;
      r_len_q     <= '0;
      r_sym_count <= '0;
      r_il_valid  <= 1'b0;
      r_il_data   <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_il_valid <= 1'b0;
      r_done     <= 1'b0;
      if (abort) begin
        r_state   <= S_IDLE;
        r_bit_cnt <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start) begin
              r_len_q     <= num_symbols;
              r_sym_count <= '0;
              r_error     <= 1'b0;
              r_bit_cnt   <= '0;
              // Zero-length frame completes without touching the interleaver
              if (num_symbols == '0) begin
                r_state <= S_DONE;
                r_done  <= 1'b1;
              end else begin
                r_state <= S_LOAD;
              end
            end
          end
          S_LOAD: begin
            if (w_xfer) begin
              r_il_valid <= 1'b1;
              r_il_data  <= src_data;
              if (r_bit_cnt == BIT_W'(NCBPS - 1)) begin
                r_bit_cnt <= '0;
                r_to_cnt  <= '0;
                r_state   <= S_WAIT_FIN;
              end else begin
                r_bit_cnt <= r_bit_cnt + BIT_W'(1);
              end
            end
          end
          S_WAIT_FIN: begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
            // A finished pulse on the expiry cycle still counts as success
            if (il_finished) begin
              r_sym_count <= w_sym_next;
              if (w_sym_next == r_len_q) begin
                r_state <= S_DONE;
                r_done  <= 1'b1;
              end else begin
                r_state <= S_LOAD;
              end
            end else if (r_to_cnt == TO_W'(TIMEOUT - 1)) begin
              r_error <= 1'b1;
              r_state <= S_IDLE;
            end
          end
          S_DONE: begin
            r_state <= S_IDLE;
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule
